// File: rtl/pll_reconfig_ctrl_pkg.sv
// pll_reconfig_ctrl_pkg: shared state codes, divider bundle and divider validity check
package pll_reconfig_ctrl_pkg;
  localparam int DIV_W = 7;
  localparam logic [DIV_W-1:0] DIV_MIN = 7'd1;
  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_READY     = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;
  typedef struct packed {
    logic [DIV_W-1:0] mdiv;
    logic [DIV_W-1:0] odiv0;
    logic [DIV_W-1:0] odiv1;
  } pll_div_t;
  function automatic logic div_ok(input pll_div_t d);
    return d.mdiv >= DIV_MIN && d.odiv0 >= DIV_MIN && d.odiv1 >= DIV_MIN;
  endfunction
endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// pll_reconfig_ctrl_if: divider reconfiguration req/ack handshake
interface pll_reconfig_ctrl_if;
  import pll_reconfig_ctrl_pkg::*;
  logic             cfg_req;
  logic [DIV_W-1:0] cfg_mdiv;
  logic [DIV_W-1:0] cfg_odiv0;
  logic [DIV_W-1:0] cfg_odiv1;
  logic             cfg_ack;
  logic             cfg_err;
  modport master (output cfg_req, cfg_mdiv, cfg_odiv0, cfg_odiv1, input cfg_ack, cfg_err);
  modport slave (input cfg_req, cfg_mdiv, cfg_odiv0, cfg_odiv1, output cfg_ack, cfg_err);
endinterface

// File: rtl/pll_reconfig_ctrl_lock_sync.sv
// lock_sync: two-flop synchroniser bringing the asynchronous PLL lock into clk
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);
  (* async_reg = "true" *) logic meta_q;
  (* async_reg = "true" *) logic sync_q;
  logic meta_d, sync_d;
  // shift the raw lock through the two-stage chain
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end
  // synchroniser registers, cleared to "unlocked"
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end
  assign sync_out = sync_q;
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: PLL reset/lock sequencer with retry limit and runtime divider reconfiguration
module pll_reconfig_ctrl import pll_reconfig_ctrl_pkg::*; #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter logic [DIV_W-1:0] MDIV_INIT  = 7'd16,
  parameter logic [DIV_W-1:0] ODIV0_INIT = 7'd8,
  parameter logic [DIV_W-1:0] ODIV1_INIT = 7'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [DIV_W-1:0] pll_mdsel,
  output logic [DIV_W-1:0] pll_odsel0,
  output logic [DIV_W-1:0] pll_odsel1,
  pll_reconfig_ctrl_if.slave cfg,
  output logic             clk_ready,
  output logic             user_rst,
  output logic             fault,
  output logic [1:0]       retry_cnt
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_END    = TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STAB_END  = SW'(LOCK_STABLE_CYCLES);
  localparam logic [1:0]    RETRY_END = 2'(MAX_RETRIES);
  localparam pll_div_t      DIV_INIT  = {MDIV_INIT, ODIV0_INIT, ODIV1_INIT};
  logic          lock_s;
  logic [2:0]    state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d, stab_inc;
  logic [1:0]    retry_q, retry_d, retry_inc;
  pll_div_t      div_q, div_d, req_div;
  logic          ack_q, ack_d, err_q, err_d, ready_q, ready_d;
  logic          user_rst_q, user_rst_d, fault_q, fault_d, pll_reset_q, pll_reset_d;

  lock_sync u_lock_sync (.clk(clk), .rst(rst), .async_in(pll_lock), .sync_out(lock_s));

  assign req_div   = {cfg.cfg_mdiv, cfg.cfg_odiv0, cfg.cfg_odiv1};
  assign to_inc    = to_cnt_q + 1'b1;
  assign stab_inc  = stab_cnt_q + 1'b1;
  assign retry_inc = retry_q + 1'b1;

  // sequencing FSM; an accepted request pre-empts lock loss in READY
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    to_cnt_d   = to_cnt_q;
    stab_cnt_d = stab_cnt_q;
    retry_d    = retry_q;
    div_d      = div_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ready_d    = ready_q;
    fault_d    = fault_q;
    if (cfg.cfg_req && (state_q == S_READY || state_q == S_FAULT)) begin
      ack_d = 1'b1;
      err_d = !div_ok(req_div);
      if (!err_d) begin
        div_d     = req_div;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        retry_d   = '0;
        state_d   = S_RESET;
        rst_cnt_d = '0;
      end
    end else begin
      case (state_q)
        S_RESET: begin
          rst_cnt_d = rst_cnt_q + 1'b1;
          if (rst_cnt_q == RST_LAST) begin
            state_d  = S_WAIT_LOCK;
            to_cnt_d = '0;
          end
        end
        S_WAIT_LOCK, S_STABLE: begin
          to_cnt_d   = to_inc;
          stab_cnt_d = (state_q == S_STABLE && lock_s) ? stab_inc : '0;
          if (state_q == S_STABLE && lock_s && stab_inc == STAB_END) begin
            state_d = S_READY;
            ready_d = 1'b1;
            retry_d = '0;
          end else if (to_inc == TO_END) begin
            retry_d   = retry_inc;
            fault_d   = retry_inc == RETRY_END;
            state_d   = fault_d ? S_FAULT : S_RESET;
            rst_cnt_d = '0;
          end else begin
            state_d = lock_s ? S_STABLE : S_WAIT_LOCK;
          end
        end
        S_READY: begin
          if (!lock_s) begin
            state_d   = S_RESET;
            ready_d   = 1'b0;
            rst_cnt_d = '0;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RESET;
      endcase
    end
    pll_reset_d = state_d == S_RESET || state_d == S_FAULT;
    user_rst_d  = !ready_d;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stab_cnt_q  <= '0;
      retry_q     <= '0;
      div_q       <= DIV_INIT;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      user_rst_q  <= 1'b1;
      fault_q     <= 1'b0;
      pll_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      retry_q     <= retry_d;
      div_q       <= div_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      user_rst_q  <= user_rst_d;
      fault_q     <= fault_d;
      pll_reset_q <= pll_reset_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_mdsel   = div_q.mdiv;
  assign pll_odsel0  = div_q.odiv0;
  assign pll_odsel1  = div_q.odiv1;
  assign cfg.cfg_ack = ack_q;
  assign cfg.cfg_err = err_q;
  assign clk_ready   = ready_q;
  assign user_rst    = user_rst_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed stimulus with an event/snapshot scoreboard checked by a negedge monitor
module tb_pll_reconfig_ctrl;
  localparam int K_PRST = 0, K_READY = 1, K_RETRY = 2, K_FAULT = 3, K_ACK = 4;
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, pll_lock, pll_reset, clk_ready, user_rst, fault;
  logic [6:0] pll_mdsel, pll_odsel0, pll_odsel1;
  logic [1:0] retry_cnt;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       done = 1'b0;
  logic       p_prst = 1'b1, p_ready = 1'b0, p_fault = 1'b0;
  logic [1:0] p_retry = 2'd0;
  ev_t        ev_q[$];
  ev_t        snap_q[$];

  pll_reconfig_ctrl_if cfg_if ();

  pll_reconfig_ctrl #(.LOCK_TIMEOUT_CYCLES(3000)) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_mdsel(pll_mdsel), .pll_odsel0(pll_odsel0), .pll_odsel1(pll_odsel1),
    .cfg(cfg_if), .clk_ready(clk_ready), .user_rst(user_rst), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] snap(input logic prst, input logic [6:0] m, o0, o1,
                                       input logic ack, err, rdy, ur, flt, input logic [1:0] rc);
    return {3'b0, prst, m, o0, o1, ack, err, rdy, ur, flt, rc};
  endfunction

  task automatic ev(input int k, input int c, input logic [31:0] v);
    ev_q.push_back('{kind: k, cyc: c, val: v});
  endtask

  task automatic prst(input int c, input logic v);
    ev(K_PRST, c, {31'b0, v});
  endtask

  task automatic rdy(input int c, input logic v);
    ev(K_READY, c, {31'b0, v});
  endtask

  task automatic ack(input int c, input logic e, input logic [6:0] m, o0, o1);
    ev(K_ACK, c, {10'b0, e, m, o0, o1});
  endtask

  task automatic snp(input int c, input logic [31:0] v);
    snap_q.push_back('{kind: 0, cyc: c, val: v});
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [6:0] m, o0, o1);
    cfg_if.cfg_mdiv  = m;
    cfg_if.cfg_odiv0 = o0;
    cfg_if.cfg_odiv1 = o1;
    cfg_if.cfg_req   = 1'b1;
  endtask

  task automatic take(input int k, input logic [31:0] v);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event cyc %0d kind %0d got %h want none", cyc, k, v);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val !== v) begin
        errors++;
        $display("FAIL event cyc %0d got kind %0d val %h want kind %0d cyc %0d val %h",
                 cyc, k, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // monitor: turns output changes into events and pops/compares scoreboard entries
  always @(negedge clk) begin
    ev_t s;
    logic [31:0] cur;
    if (cyc > 0) begin
      checks++;
      if (user_rst !== !clk_ready) begin
        errors++;
        $display("FAIL user_rst cyc %0d got %b want %b", cyc, user_rst, !clk_ready);
      end
      if (pll_reset !== p_prst) take(K_PRST, {31'b0, pll_reset});
      if (clk_ready !== p_ready) take(K_READY, {31'b0, clk_ready});
      if (retry_cnt !== p_retry) take(K_RETRY, {30'b0, retry_cnt});
      if (fault !== p_fault) take(K_FAULT, {31'b0, fault});
      if (cfg_if.cfg_ack !== 1'b0) take(K_ACK, {10'b0, cfg_if.cfg_err, pll_mdsel, pll_odsel0, pll_odsel1});
      cur = snap(pll_reset, pll_mdsel, pll_odsel0, pll_odsel1, cfg_if.cfg_ack, cfg_if.cfg_err,
                 clk_ready, user_rst, fault, retry_cnt);
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        checks++;
        if (s.cyc != cyc || cur !== s.val) begin
          errors++;
          $display("FAIL snapshot cyc %0d got %h want %h at cyc %0d", cyc, cur, s.val, s.cyc);
        end
      end
      p_prst  = pll_reset;
      p_ready = clk_ready;
      p_retry = retry_cnt;
      p_fault = fault;
      if (done || cyc >= 20000) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL watchdog cyc %0d got running want done", cyc);
        end
        checks++;
        if (ev_q.size() != 0) begin
          errors++;
          $display("FAIL pending_events got %0d want 0 (next kind %0d cyc %0d)", ev_q.size(), ev_q[0].kind, ev_q[0].cyc);
        end
        checks++;
        if (snap_q.size() != 0) begin
          errors++;
          $display("FAIL pending_snapshots got %0d want 0", snap_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // stimulus with hand-computed event cycles (lock path latency = 2 sync + 1 FSM + 1024 stable)
  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    cfg_if.cfg_req = 1'b0;
    cfg_if.cfg_mdiv = 7'd0;
    cfg_if.cfg_odiv0 = 7'd0;
    cfg_if.cfg_odiv1 = 7'd0;
    snp(2, snap(1'b1, 7'd16, 7'd8, 7'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    goto(3);
    rst = 1'b0;
    prst(19, 1'b0);
    goto(103);
    pll_lock = 1'b1;
    rdy(1130, 1'b1);
    goto(1200);
    pll_lock = 1'b0;
    prst(1203, 1'b1);
    rdy(1203, 1'b0);
    prst(1219, 1'b0);
    goto(1240);
    pll_lock = 1'b1;
    rdy(2771, 1'b1);
    goto(1743);
    pll_lock = 1'b0;
    goto(1744);
    pll_lock = 1'b1;
    goto(2800);
    req(7'd20, 7'd10, 7'd5);
    prst(2801, 1'b1);
    rdy(2801, 1'b0);
    ack(2801, 1'b0, 7'd20, 7'd10, 7'd5);
    prst(2817, 1'b0);
    rdy(3842, 1'b1);
    snp(2810, snap(1'b1, 7'd20, 7'd10, 7'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    goto(2801);
    cfg_if.cfg_req = 1'b0;
    goto(3900);
    req(7'd30, 7'd12, 7'd0);
    ack(3901, 1'b1, 7'd20, 7'd10, 7'd5);
    snp(3905, snap(1'b0, 7'd20, 7'd10, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
    goto(3901);
    cfg_if.cfg_req = 1'b0;
    goto(3950);
    pll_lock = 1'b0;
    prst(3953, 1'b1);
    rdy(3953, 1'b0);
    prst(3969, 1'b0);
    goto(3980);
    req(7'd25, 7'd11, 7'd6);
    goto(4010);
    pll_lock = 1'b1;
    rdy(5037, 1'b1);
    prst(5038, 1'b1);
    rdy(5038, 1'b0);
    ack(5038, 1'b0, 7'd25, 7'd11, 7'd6);
    prst(5054, 1'b0);
    rdy(6079, 1'b1);
    goto(5038);
    cfg_if.cfg_req = 1'b0;
    goto(6100);
    pll_lock = 1'b0;
    prst(6103, 1'b1);
    rdy(6103, 1'b0);
    prst(6119, 1'b0);
    goto(6130);
    pll_lock = 1'b1;
    goto(6330);
    rst = 1'b1;
    prst(6331, 1'b1);
    snp(6332, snap(1'b1, 7'd16, 7'd8, 7'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    goto(6331);
    rst = 1'b0;
    pll_lock = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      prst(6331 + 16 + (k - 1) * 3016, 1'b0);
      prst(6331 + k * 3016, 1'b1);
      ev(K_RETRY, 6331 + k * 3016, 32'(k));
    end
    ev(K_FAULT, 15379, 32'd1);
    snp(15450, snap(1'b1, 7'd16, 7'd8, 7'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3));
    goto(15460);
    req(7'd0, 7'd5, 7'd5);
    ack(15461, 1'b1, 7'd16, 7'd8, 7'd4);
    goto(15461);
    cfg_if.cfg_req = 1'b0;
    goto(15470);
    req(7'd20, 7'd10, 7'd5);
    ev(K_RETRY, 15471, 32'd0);
    ev(K_FAULT, 15471, 32'd0);
    ack(15471, 1'b0, 7'd20, 7'd10, 7'd5);
    prst(15487, 1'b0);
    goto(15471);
    cfg_if.cfg_req = 1'b0;
    goto(15500);
    done = 1'b1;
  end
endmodule
